// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and frame geometry.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with an occupancy count.
// A push and a pop in the same cycle both take effect.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is pure data; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed from a small byte FIFO; frames go out
// back-to-back while bytes are queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e     state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            tx_nxt;
  logic            pop;
  logic            push;
  logic            bit_end;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic [CNTW-1:0] cnt_after;

  assign push      = in_valid && in_ready;
  assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
  assign cnt_after = fifo_count + CNTW'(push) - CNTW'(pop);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    if (state != IDLE) cnt_nxt = bit_end ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_nxt = fifo_dout;
          state_nxt = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          idx_nxt   = idx + 1'b1;
          if (idx == 3'(DATA_BITS - 1)) begin
            idx_nxt   = '0;
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          idx_nxt = idx + 1'b1;
          if (idx == 3'(STOP_BITS - 1)) begin
            idx_nxt = '0;
            // Chain straight into the next start bit when more bytes wait.
            if (!fifo_empty) begin
              pop       = 1'b1;
              shreg_nxt = fifo_dout;
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx and busy are registered one cycle behind the state they reflect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      tx       <= tx_nxt;
      busy     <= (state != IDLE) || (fifo_count != '0);
      in_ready <= (cnt_after != CNTW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

endmodule
